// File: rtl/aes_pipe_ct_fifo.sv
// ----------------------------------------------------------------------------
// aes_pipe_ct_fifo
//
// Ciphertext collection stage behind the pipelined AES core. Every result the
// pipeline emits is captured (the pipeline cannot be stalled) into a circular
// buffer and handed to the register interface one word per pop. The block
// also counts plaintexts that are still inside the pipeline so the register
// block can report a busy state.
//
// Ports:
//   crypto_clk      in   sole clock, rising edge
//   reset_i         in   synchronous active-high reset, highest priority
//   issue_i         in   pulse: a plaintext entered the AES pipeline
//   ct_valid_i      in   pipeline result valid (may be high every cycle)
//   ct_data_i       in   pipeline result, qualified by ct_valid_i
//   pop_i           in   pulse: register block consumes the head word
//   clear_i         in   clears the sticky error flags
//   ct_out_o        out  last popped word, held until the next good pop
//   ct_out_valid_o  out  one-cycle strobe after a successful pop
//   empty_o         out  buffer holds no words
//   full_o          out  buffer holds pDEPTH words
//   count_o         out  buffer occupancy
//   inflight_o      out  plaintexts issued whose result has not arrived
//   busy_o          out  work in the pipeline and nothing to read yet
//   overflow_o      out  sticky: result dropped or in-flight count saturated
//   underflow_o     out  sticky: pop on empty, or result with nothing issued
// ----------------------------------------------------------------------------
module aes_pipe_ct_fifo #(
  parameter int pDATA_WIDTH = 128,
  parameter int pDEPTH      = 32,
  parameter int pCNT_WIDTH  = 6
) (
  input  logic                   crypto_clk,
  input  logic                   reset_i,
  input  logic                   issue_i,
  input  logic                   ct_valid_i,
  input  logic [pDATA_WIDTH-1:0] ct_data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output logic [pDATA_WIDTH-1:0] ct_out_o,
  output logic                   ct_out_valid_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [pCNT_WIDTH-1:0]  count_o,
  output logic [pCNT_WIDTH-1:0]  inflight_o,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int PTR_W = $clog2(pDEPTH);

  localparam logic [pCNT_WIDTH-1:0] CNT_ZERO  = '0;
  localparam logic [pCNT_WIDTH-1:0] CNT_ONE   = pCNT_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [pCNT_WIDTH-1:0] CNT_DEPTH = pCNT_WIDTH'(pDEPTH);
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);

  // Storage: no reset so it maps onto block RAM; validity is tracked
  // entirely by the pointers and the occupancy counter.
  logic [pDATA_WIDTH-1:0] mem [pDEPTH];

  logic [PTR_W-1:0]       wr_ptr_reg,   wr_ptr_next;
  logic [PTR_W-1:0]       rd_ptr_reg,   rd_ptr_next;
  logic [pCNT_WIDTH-1:0]  count_reg,    count_next;
  logic [pCNT_WIDTH-1:0]  inflight_reg, inflight_next;
  logic                   empty_reg,    empty_next;
  logic                   full_reg,     full_next;
  logic                   busy_reg,     busy_next;
  logic                   overflow_reg, overflow_next;
  logic                   underflow_reg, underflow_next;
  logic [pDATA_WIDTH-1:0] ct_out_reg;
  logic                   ct_out_valid_reg;

  logic push_ok;
  logic pop_ok;
  logic issue_sat;
  logic valid_orphan;
  logic overflow_event;
  logic underflow_event;

  always_comb begin
    // Pop is judged on the registered (pre-edge) empty flag, so a word
    // arriving in the same cycle cannot be bypassed straight to the output.
    pop_ok  = pop_i && !empty_reg;
    // A full buffer can still take a word when the head leaves in the same
    // cycle: the write lands in the slot being read, and the read sees the
    // old contents because both happen on the same edge.
    push_ok = ct_valid_i && (!full_reg || pop_ok);

    wr_ptr_next = push_ok ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
    rd_ptr_next = pop_ok  ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;

    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CNT_ONE;
    end

    // In-flight tracking: an issue and an arriving result in the same cycle
    // cancel out, so neither the saturation nor the orphan check applies.
    inflight_next = inflight_reg;
    issue_sat     = 1'b0;
    valid_orphan  = 1'b0;
    if (issue_i && !ct_valid_i) begin
      if (inflight_reg == CNT_MAX) begin
        issue_sat = 1'b1;
      end else begin
        inflight_next = inflight_reg + CNT_ONE;
      end
    end else if (ct_valid_i && !issue_i) begin
      if (inflight_reg == CNT_ZERO) begin
        valid_orphan = 1'b1;
      end else begin
        inflight_next = inflight_reg - CNT_ONE;
      end
    end

    overflow_event  = (ct_valid_i && !push_ok) || issue_sat;
    underflow_event = (pop_i && empty_reg) || valid_orphan;

    // A fresh error event outranks a clear in the same cycle.
    overflow_next = overflow_reg;
    if (overflow_event) begin
      overflow_next = 1'b1;
    end else if (clear_i) begin
      overflow_next = 1'b0;
    end

    underflow_next = underflow_reg;
    if (underflow_event) begin
      underflow_next = 1'b1;
    end else if (clear_i) begin
      underflow_next = 1'b0;
    end

    // Status flags are derived from next-state values so they line up with
    // count_o and inflight_o in the same cycle.
    empty_next = (count_next == CNT_ZERO);
    full_next  = (count_next == CNT_DEPTH);
    busy_next  = (inflight_next != CNT_ZERO) && empty_next;
  end

  always_ff @(posedge crypto_clk) begin
    if (push_ok && !reset_i) begin
      mem[wr_ptr_reg] <= ct_data_i;
    end
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      inflight_reg     <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      busy_reg         <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
      ct_out_reg       <= '0;
      ct_out_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      inflight_reg     <= inflight_next;
      empty_reg        <= empty_next;
      full_reg         <= full_next;
      busy_reg         <= busy_next;
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
      ct_out_valid_reg <= pop_ok;
      if (pop_ok) begin
        ct_out_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign ct_out_o       = ct_out_reg;
  assign ct_out_valid_o = ct_out_valid_reg;
  assign empty_o        = empty_reg;
  assign full_o         = full_reg;
  assign count_o        = count_reg;
  assign inflight_o     = inflight_reg;
  assign busy_o         = busy_reg;
  assign overflow_o     = overflow_reg;
  assign underflow_o    = underflow_reg;

endmodule

// File: tb/tb_aes_pipe_ct_fifo.sv
module tb_aes_pipe_ct_fifo;

  localparam int DW    = 128;
  localparam int DEPTH = 32;
  localparam int CW    = 6;
  localparam int VW    = DW + 3 + 2 * CW + 3;

  logic          crypto_clk;
  logic          reset_i;
  logic          issue_i;
  logic          ct_valid_i;
  logic [DW-1:0] ct_data_i;
  logic          pop_i;
  logic          clear_i;
  logic [DW-1:0] ct_out_o;
  logic          ct_out_valid_o;
  logic          empty_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic [CW-1:0] inflight_o;
  logic          busy_o;
  logic          overflow_o;
  logic          underflow_o;

  aes_pipe_ct_fifo #(
    .pDATA_WIDTH(DW),
    .pDEPTH     (DEPTH),
    .pCNT_WIDTH (CW)
  ) dut (
    .crypto_clk    (crypto_clk),
    .reset_i       (reset_i),
    .issue_i       (issue_i),
    .ct_valid_i    (ct_valid_i),
    .ct_data_i     (ct_data_i),
    .pop_i         (pop_i),
    .clear_i       (clear_i),
    .ct_out_o      (ct_out_o),
    .ct_out_valid_o(ct_out_valid_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .count_o       (count_o),
    .inflight_o    (inflight_o),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  initial crypto_clk = 1'b0;
  always #5 crypto_clk = ~crypto_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of stored words plus plain integer counters.
  logic [DW-1:0] m_q[$];
  int            m_inf;
  logic [DW-1:0] m_out;
  bit            m_vld;
  bit            m_ovf;
  bit            m_unf;

  localparam logic [DW-1:0] W_A = 128'h8a278bf8fa2812bc39e52c76205af377;
  localparam logic [DW-1:0] W_B = 128'h0efee0bff4cf170752994fb45bd45934;

  function automatic logic [VW-1:0] exp_vec();
    int n;
    n = m_q.size();
    return {m_out, m_vld, (n == 0), (n == DEPTH), CW'(n), CW'(m_inf),
            (m_inf != 0 && n == 0), m_ovf, m_unf};
  endfunction

  wire [VW-1:0] dut_vec = {ct_out_o, ct_out_valid_o, empty_o, full_o, count_o,
                           inflight_o, busy_o, overflow_o, underflow_o};

  task automatic model_step(input bit iss, input bit vld, input logic [DW-1:0] d,
                            input bit pp, input bit clr, input bit rst);
    bit pop_ok, push_ok, ovf_ev, unf_ev;
    if (rst) begin
      m_q.delete();
      m_inf = 0; m_out = '0; m_vld = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    pop_ok  = pp && (m_q.size() > 0);
    push_ok = vld && ((m_q.size() < DEPTH) || pop_ok);
    ovf_ev  = vld && !push_ok;
    unf_ev  = pp && (m_q.size() == 0);
    m_vld   = pop_ok;
    if (pop_ok) m_out = m_q.pop_front();
    if (push_ok) m_q.push_back(d);
    if (iss && !vld) begin
      if (m_inf == (1 << CW) - 1) ovf_ev = 1;
      else m_inf++;
    end else if (vld && !iss) begin
      if (m_inf == 0) unf_ev = 1;
      else m_inf--;
    end
    m_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = unf_ev ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, and
  // leave the bench 1 time unit after the edge ready to sample.
  task automatic cycle(input bit iss, input bit vld, input logic [DW-1:0] d,
                       input bit pp, input bit clr, input bit rst);
    issue_i = iss; ct_valid_i = vld; ct_data_i = d;
    pop_i = pp; clear_i = clr; reset_i = rst;
    @(posedge crypto_clk);
    model_step(iss, vld, d, pp, clr, rst);
    #1;
    issue_i = 0; ct_valid_i = 0; pop_i = 0; clear_i = 0; reset_i = 0;
  endtask

  task automatic test_reset();
    cycle(0, 0, '0, 0, 0, 1);
    cycle(0, 0, '0, 0, 0, 1);
    n_vec++;
    if (dut_vec !== {128'h0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", dut_vec,
               {128'h0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_single();
    cycle(0, 0, '0, 0, 0, 1);
    cycle(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (busy_o !== 1'b1 || inflight_o !== 6'd1) begin
        n_err++;
        $display("FAIL single_busy: busy=%b inflight=%0d want busy=1 inflight=1", busy_o, inflight_o);
      end
      cycle(0, 0, '0, 0, 0, 0);
    end
    cycle(0, 1, W_A, 0, 0, 0);
    n_vec++;
    if (busy_o !== 1'b0 || count_o !== 6'd1 || empty_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_push: busy=%b count=%0d empty=%b want 0/1/0", busy_o, count_o, empty_o);
    end
    cycle(0, 0, '0, 1, 0, 0);
    n_vec++;
    if (ct_out_o !== W_A || ct_out_valid_o !== 1'b1 || empty_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_pop: out=%h vld=%b empty=%b want %h/1/1", ct_out_o, ct_out_valid_o, empty_o, W_A);
    end
    cycle(0, 0, '0, 0, 0, 0);
    n_vec++;
    if (ct_out_valid_o !== 1'b0 || ct_out_o !== W_A) begin
      n_err++;
      $display("FAIL single_hold: out=%h vld=%b want %h/0", ct_out_o, ct_out_valid_o, W_A);
    end
  endtask

  task automatic test_back_to_back();
    cycle(0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cycle(1, 0, '0, 0, 0, 0);
    n_vec++;
    if (inflight_o !== 6'd20) begin
      n_err++;
      $display("FAIL b2b_inflight: got %0d want 20", inflight_o);
    end
    for (int i = 0; i < 20; i++) cycle(0, 1, W_B, 0, 0, 0);
    n_vec++;
    if (inflight_o !== 6'd0 || count_o !== 6'd20 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_fill: inflight=%0d count=%0d busy=%b want 0/20/0", inflight_o, count_o, busy_o);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, '0, 1, 0, 0);
      n_vec++;
      if (ct_out_o !== W_B || ct_out_valid_o !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_pop%0d: out=%h vld=%b want %h/1", i, ct_out_o, ct_out_valid_o, W_B);
      end
    end
    n_vec++;
    if (overflow_o !== 1'b0 || underflow_o !== 1'b0 || empty_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_flags: ovf=%b unf=%b empty=%b want 0/0/1", overflow_o, underflow_o, empty_o);
    end
  endtask

  task automatic test_full();
    cycle(0, 0, '0, 0, 0, 1);
    for (int i = 1; i <= 33; i++) begin
      cycle(1, 0, '0, 0, 0, 0);
      cycle(0, 1, DW'(i), 0, 0, 0);
      if (i == 32) begin
        n_vec++;
        if (full_o !== 1'b1 || overflow_o !== 1'b0 || count_o !== 6'd32) begin
          n_err++;
          $display("FAIL full_at32: full=%b ovf=%b count=%0d want 1/0/32", full_o, overflow_o, count_o);
        end
      end
    end
    n_vec++;
    if (full_o !== 1'b1 || overflow_o !== 1'b1 || count_o !== 6'd32) begin
      n_err++;
      $display("FAIL full_drop: full=%b ovf=%b count=%0d want 1/1/32", full_o, overflow_o, count_o);
    end
    for (int i = 1; i <= 32; i++) begin
      cycle(0, 0, '0, 1, 0, 0);
      n_vec++;
      if (ct_out_o !== DW'(i)) begin
        n_err++;
        $display("FAIL full_order%0d: got %h want %h", i, ct_out_o, DW'(i));
      end
    end
    n_vec++;
    if (empty_o !== 1'b1 || count_o !== 6'd0) begin
      n_err++;
      $display("FAIL full_drain: empty=%b count=%0d want 1/0", empty_o, count_o);
    end
  endtask

  task automatic test_full_push_pop();
    cycle(0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 32; i++) cycle(1, 1, DW'(100 + i), 0, 0, 0);
    cycle(1, 1, DW'(8'hAA), 1, 0, 0);
    n_vec++;
    if (count_o !== 6'd32 || overflow_o !== 1'b0 || ct_out_o !== DW'(100)) begin
      n_err++;
      $display("FAIL fullpp: count=%0d ovf=%b out=%h want 32/0/%h", count_o, overflow_o, ct_out_o, DW'(100));
    end
    for (int i = 0; i < 32; i++) cycle(0, 0, '0, 1, 0, 0);
    n_vec++;
    if (ct_out_o !== DW'(8'hAA) || empty_o !== 1'b1) begin
      n_err++;
      $display("FAIL fullpp_last: out=%h empty=%b want %h/1", ct_out_o, empty_o, DW'(8'hAA));
    end
  endtask

  task automatic test_underflow();
    cycle(0, 0, '0, 0, 0, 1);
    cycle(1, 1, W_A, 0, 0, 0);
    cycle(0, 0, '0, 1, 0, 0);
    cycle(0, 0, '0, 1, 0, 0);
    n_vec++;
    if (underflow_o !== 1'b1 || ct_out_o !== W_A || ct_out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL unf_pop: unf=%b out=%h vld=%b want 1/%h/0", underflow_o, ct_out_o, ct_out_valid_o, W_A);
    end
    cycle(0, 0, '0, 0, 1, 0);
    n_vec++;
    if (underflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL unf_clear: got %b want 0", underflow_o);
    end
    cycle(0, 1, W_B, 0, 1, 0);
    n_vec++;
    if (underflow_o !== 1'b1 || count_o !== 6'd1 || inflight_o !== 6'd0) begin
      n_err++;
      $display("FAIL unf_orphan: unf=%b count=%0d inflight=%0d want 1/1/0", underflow_o, count_o, inflight_o);
    end
    cycle(0, 1, W_A, 1, 0, 0);
    n_vec++;
    if (ct_out_o !== W_B || count_o !== 6'd1) begin
      n_err++;
      $display("FAIL unf_stored: out=%h count=%0d want %h/1", ct_out_o, count_o, W_B);
    end
  endtask

  task automatic test_mid_reset();
    cycle(0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 13; i++) cycle(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, DW'(i + 500), 0, 0, 0);
    n_vec++;
    if (count_o !== 6'd10 || inflight_o !== 6'd3) begin
      n_err++;
      $display("FAIL midrst_pre: count=%0d inflight=%0d want 10/3", count_o, inflight_o);
    end
    cycle(1, 1, W_A, 1, 0, 1);
    n_vec++;
    if (dut_vec !== {128'h0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_state: got %h want %h", dut_vec,
               {128'h0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0});
    end
    cycle(1, 0, '0, 0, 0, 0);
    cycle(0, 1, W_B, 0, 0, 0);
    cycle(0, 0, '0, 1, 0, 0);
    n_vec++;
    if (ct_out_o !== W_B || ct_out_valid_o !== 1'b1 || empty_o !== 1'b1 || underflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_after: out=%h vld=%b empty=%b unf=%b want %h/1/1/0",
               ct_out_o, ct_out_valid_o, empty_o, underflow_o, W_B);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    bit iss, vld, pp, clr, rst;
    cycle(0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      d   = {$urandom, $urandom, $urandom, $urandom};
      iss = ($urandom_range(99) < 45);
      vld = ($urandom_range(99) < 45);
      pp  = ($urandom_range(99) < ((i / 500) % 2 == 0 ? 30 : 60));
      clr = ($urandom_range(99) < 4);
      rst = ($urandom_range(999) < 3);
      cycle(iss, vld, d, pp, clr, rst);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset_i = 1; issue_i = 0; ct_valid_i = 0; ct_data_i = '0;
    pop_i = 0; clear_i = 0;
    m_inf = 0; m_out = '0; m_vld = 0; m_ovf = 0; m_unf = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_full_push_pop();
    test_underflow();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
